// File: rtl/pdm_pkg.sv
// Shared types and helpers for the PDM microphone audio path.
// PCM sample type plus the clamp used after wide filter arithmetic.
package pdm_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned WIDE_W = DATA_W + 2;

    typedef logic signed [DATA_W-1:0] pcm_t;

    // Clamp a DATA_W+2 bit signed value into the PCM range.
    function automatic pcm_t sat_pcm(input logic signed [WIDE_W-1:0] v);
        logic [2:0] top;
        top = v[WIDE_W-1:DATA_W-1];
        if ((&top) || !(|top)) begin
            sat_pcm = v[DATA_W-1:0];
        end else if (v[WIDE_W-1]) begin
            sat_pcm = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat_pcm = {1'b0, {(DATA_W-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/pcm_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with explicit occupancy count.
// Push while full is accepted only together with a pop; rdata is 0 when empty.
module pcm_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign level   = level_q;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                level_d = level_q + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                level_d = level_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/pcm_dcblock_fifo.sv
// DC-blocking high-pass (leaky integrator) on CIC PCM samples, buffered in a FWFT FIFO
// with a level watermark interrupt and a sticky overflow flag.
module pcm_dcblock_fifo #(
    parameter int unsigned DATA_W  = pdm_pkg::DATA_W,
    parameter int unsigned DEPTH   = pdm_pkg::DEPTH,
    parameter int unsigned K_SHIFT = 8,
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              hp_bypass,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic [LVL_W-1:0]  level,
    input  logic [LVL_W-1:0]  watermark,
    output logic              irq,
    output logic              overflow,
    input  logic              clr_overflow
);

    import pdm_pkg::*;

    // Wide enough that dc_acc, bounded by |x| * 2^K_SHIFT, never wraps.
    localparam int unsigned ACC_W = DATA_W + K_SHIFT + 1;

    logic                     in_valid_q, in_valid_d;
    logic signed [DATA_W-1:0] x_q, x_d;
    logic                     pend_q, pend_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     ovf_q, ovf_d;

    logic                     sample_evt;
    logic signed [ACC_W-1:0]  x_wide;
    logic signed [ACC_W-1:0]  diff_w;
    pcm_t                     y;
    logic [DATA_W-1:0]        push_data;
    logic                     push;
    logic                     fifo_full;

    assign sample_evt = in_valid & ~in_valid_q & enable;
    assign x_wide     = {{(ACC_W-DATA_W){x_q[DATA_W-1]}}, x_q};
    // x - (dc_acc >>> K); the same difference both feeds the output and updates the estimate.
    assign diff_w     = x_wide - (acc_q >>> K_SHIFT);
    assign y          = sat_pcm(diff_w[DATA_W+1:0]);
    assign push_data  = hp_bypass ? x_q : y;
    assign push       = pend_q & enable;

    always_comb begin
        in_valid_d = in_valid;
        x_d        = x_q;
        pend_d     = 1'b0;
        acc_d      = acc_q;
        if (!enable) begin
            acc_d = '0;
        end else begin
            if (sample_evt) begin
                x_d    = in_data;
                pend_d = 1'b1;
            end
            if (pend_q) begin
                acc_d = acc_q + diff_w;
            end
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (push && fifo_full && !rd_en) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_valid_q <= 1'b0;
            x_q        <= '0;
            pend_q     <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            in_valid_q <= in_valid_d;
            x_q        <= x_d;
            pend_q     <= pend_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
        end
    end

    pcm_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (~enable),
        .push  (push),
        .pop   (rd_en),
        .wdata (push_data),
        .rdata (rd_data),
        .level (level),
        .full  (fifo_full),
        .empty (empty)
    );

    assign irq      = (watermark != '0) && (level >= watermark);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pcm_dcblock_fifo.sv
// Scoreboard bench for pcm_dcblock_fifo: expected samples are queued at stimulus time
// and a negedge monitor checks rd_data whenever a pop is presented.
module tb_pcm_dcblock_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int K     = 4;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable, hp_bypass, in_valid, rd_en, clr_overflow;
    logic [DW-1:0] in_data;
    logic [DW-1:0] rd_data;
    logic          empty, irq, overflow;
    logic [LW-1:0] level, watermark;

    int     total = 0;
    int     bad   = 0;
    int     exp_q[$];
    longint acc_m;

    pcm_dcblock_fifo #(
        .DATA_W  (DW),
        .DEPTH   (DEPTH),
        .K_SHIFT (K)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .hp_bypass    (hp_bypass),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .level        (level),
        .watermark    (watermark),
        .irq          (irq),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Reference leaky integrator: dc = acc >>> K, y = sat(x - dc), acc += x - dc.
    function automatic int filt(input int x, input bit byp);
        longint dc, d;
        int     y;
        dc = acc_m >>> K;
        d  = longint'(x) - dc;
        if (d > 32767) y = 32767;
        else if (d < -32768) y = -32768;
        else y = int'(d);
        acc_m = acc_m + d;
        return byp ? x : y;
    endfunction

    always @(negedge clk) begin
        if (!rst && rd_en && !empty) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got %0d expected no data", $signed(rd_data));
            end else begin
                chk("pop_data", int'($signed(rd_data)), exp_q.pop_front());
            end
        end
    end

    task automatic send(input int x, input bit do_pop = 1'b0, input bit do_clr = 1'b0);
        int e;
        e        = filt(x, hp_bypass);
        in_data  = DW'(x);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid     = 1'b0;
        rd_en        = do_pop;
        clr_overflow = do_clr;
        @(posedge clk); #1;
        rd_en        = 1'b0;
        clr_overflow = 1'b0;
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
    endtask

    task automatic pop1();
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < DEPTH + 2 && !empty; i++) pop1();
        chk(name, int'(empty), 1);
        chk({name, "_sb"}, exp_q.size(), 0);
    endtask

    task automatic flush_en();
        enable = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
        exp_q.delete();
        acc_m = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; enable = 1'b1; hp_bypass = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
        clr_overflow = 1'b0; in_data = '0; watermark = '0; acc_m = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_empty", int'(empty), 1);
        chk("rst_level", int'(level), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_irq", int'(irq), 0);
        chk("rst_overflow", int'(overflow), 0);
        @(posedge clk); #1;

        // Filter: constant 1000 gives 1000, 938, 879
        send(1000); send(1000); send(1000);
        chk("filt_level", int'(level), 3);
        chk("filt_head", int'($signed(rd_data)), 1000);
        drain("filt_drain");

        // Bypass and two-edge latency
        hp_bypass = 1'b1;
        in_data   = DW'(-5);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        chk("lat_e1_empty", int'(empty), 1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("lat_e2_level", int'(level), 1);
        chk("lat_e2_data", int'($signed(rd_data)), -5);
        exp_q.push_back(filt(-5, 1'b1));
        send(7);
        drain("byp_drain");

        // Watermark, fill, overflow
        watermark = 4'd3;
        send(10); send(20);
        chk("wm_irq_l2", int'(irq), 0);
        send(30);
        chk("wm_irq_l3", int'(irq), 1);
        pop1();
        chk("wm_irq_pop", int'(irq), 0);
        for (int i = 0; i < 7; i++) send(100 + i);
        chk("ovf_level", int'(level), 8);
        chk("ovf_flag", int'(overflow), 1);
        chk("full_irq", int'(irq), 1);
        watermark = 4'd0;
        #1 chk("wm0_irq", int'(irq), 0);
        drain("ovf_drain");
        chk("ovf_sticky", int'(overflow), 1);
        clr_overflow = 1'b1;
        @(posedge clk); #1;
        clr_overflow = 1'b0;
        chk("ovf_clr", int'(overflow), 0);

        // Drop in the same cycle as clr: set wins
        for (int i = 0; i < 8; i++) send(-200 - i);
        send(999, 1'b0, 1'b1);
        chk("ovf_set_prio", int'(overflow), 1);
        chk("ovf_set_level", int'(level), 8);
        clr_overflow = 1'b1;
        @(posedge clk); #1;
        clr_overflow = 1'b0;

        // Full with simultaneous push and pop
        send(555, 1'b1);
        chk("fullpp_level", int'(level), 8);
        chk("fullpp_ovf", int'(overflow), 0);
        drain("fullpp_drain");

        // Saturation on a large negative step after settling at full scale
        flush_en();
        hp_bypass = 1'b0;
        n = 0;
        while ((acc_m >>> K) < 32000 && n < 400) begin
            send(32767);
            pop1();
            n++;
        end
        chk("sat_reach", int'((acc_m >>> K) >= 32000), 1);
        send(-32768);
        chk("sat_out", int'($signed(rd_data)), -32768);
        drain("sat_drain");

        // Enable drop flushes; re-enable with in_valid held high does not push
        send(100); send(200);
        chk("en_level", int'(level), 2);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("dis_level", int'(level), 0);
        chk("dis_empty", int'(empty), 1);
        exp_q.delete();
        acc_m    = 0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("reen_nopush", int'(level), 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        send(500);
        chk("reen_level", int'(level), 1);
        chk("reen_dc_clear", int'($signed(rd_data)), 500);
        drain("reen_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
